// File: rtl/register_rw_if.sv
// ---------------------------------------------------------------------------
// register_rw_if
//
// Purpose: bundles the data-side signals of the register_rw storage element
//          so that the register and whatever drives it share one port.
//
// Signals:
//    rw       1      1 = capture `write` on the next rising clock edge,
//                    0 = hold the current contents
//    write    WIDTH  data to be captured
//    read     WIDTH  current register contents (or forwarded write data
//                    when the write-through option is built in)
//    updated  1      one-cycle pulse after an edge that changed the value
//
// Modports:
//    master   drives rw/write, observes read/updated
//    slave    the register itself
// ---------------------------------------------------------------------------
interface register_rw_if #(
   parameter int WIDTH = 16
);
   logic             rw;
   logic [WIDTH-1:0] write;
   logic [WIDTH-1:0] read;
   logic             updated;

   modport master (
      output rw,
      output write,
      input  read,
      input  updated
   );

   modport slave (
      input  rw,
      input  write,
      output read,
      output updated
   );
endinterface

// File: rtl/register_rw.sv
// ---------------------------------------------------------------------------
// register_rw
//
// Purpose: single WIDTH-bit storage register with one read/write select.
//          Used as the basic cell of the register file and for standalone
//          processor state such as PC, IR and the accumulator.
//
// Parameters:
//    WIDTH        data width of write/read
//    RESET_VALUE  contents after reset
//
// Ports:
//    clk      input   rising-edge clock
//    rst_n    input   asynchronous active-low reset
//    bus      slave   register_rw_if: rw, write (in); read, updated (out)
//
// Build option:
//    REGISTER_RW_BYPASS_EN  when defined, `read` forwards `write`
//                           combinationally while rw=1 so the new value is
//                           visible in the same cycle it is written. While
//                           rst_n is low `read` still shows RESET_VALUE.
//                           When undefined, `read` is the stored value only.
// ---------------------------------------------------------------------------
module register_rw #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   register_rw_if.slave  bus
);

   logic [WIDTH-1:0] q;
   logic             updated_q;

   // The change test compares against the value held before this edge, so
   // rewriting the same data leaves `updated` low. An X on `write` is
   // captured as-is; nothing here masks it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q         <= RESET_VALUE;
         updated_q <= 1'b0;
      end else begin
         if (bus.rw) begin
            q <= bus.write;
         end
         updated_q <= bus.rw && (bus.write != q);
      end
   end

   assign bus.updated = updated_q;

`ifdef REGISTER_RW_BYPASS_EN
   // Reset has to override forwarding, otherwise a write pending during
   // reset would leak onto `read` while the flops are held cleared.
   assign bus.read = !rst_n ? RESET_VALUE
                   : (bus.rw ? bus.write : q);
`else
   assign bus.read = q;
`endif

endmodule

// File: tb/tb_register_rw.sv
// ---------------------------------------------------------------------------
// tb_register_rw
//
// Directed bench for register_rw. The stimulus process pushes the expected
// {read, updated} pair into a queue; a separate monitor pops and compares
// on each falling clock edge, or immediately when the stimulus fires a probe
// event for checks that must land between clock edges (async reset,
// bypass forwarding).
// ---------------------------------------------------------------------------
module tb_register_rw;

   localparam int WIDTH = 16;

   typedef struct {
      logic [WIDTH-1:0] read;
      logic             updated;
      string            name;
   } exp_t;

   logic clk;
   logic rst_n;

   register_rw_if #(.WIDTH(WIDTH)) bus ();

   register_rw #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (16'h0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t exp_q[$];
   event probe_ev;
   int   n_compared = 0;
   int   n_failed   = 0;
   bit   stim_done  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: consumes whatever the stimulus queued for this sample point.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk or probe_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_compared++;
            if (bus.read !== e.read || bus.updated !== e.updated) begin
               n_failed++;
               $display("FAIL %s: read=%h updated=%b, required read=%h updated=%b",
                        e.name, bus.read, bus.updated, e.read, e.updated);
            end else begin
               $display("ok   %s: read=%h updated=%b", e.name, bus.read, bus.updated);
            end
         end
      end
   end

   function automatic void expect_val(input logic [WIDTH-1:0] r, input logic u,
                                      input string nm);
      exp_t e;
      e.read    = r;
      e.updated = u;
      e.name    = nm;
      exp_q.push_back(e);
   endfunction

   // One clock edge with the given inputs; expectation checked at the
   // following falling edge. Inputs change 1 ns after that falling edge.
   task automatic step(input logic r, input logic [WIDTH-1:0] w,
                       input logic [WIDTH-1:0] er, input logic eu,
                       input string nm);
      bus.rw    = r;
      bus.write = w;
      @(posedge clk);
      expect_val(er, eu, nm);
      @(negedge clk);
      #1;
   endtask

   // Check taken right now, between clock edges.
   task automatic probe(input logic [WIDTH-1:0] er, input logic eu,
                        input string nm);
      expect_val(er, eu, nm);
      ->probe_ev;
      #0;
   endtask

   initial begin : watchdog
      #50000;
      if (!stim_done) begin
         $display("FAIL watchdog: stimulus still running at %0t, required done", $time);
         $fatal(1, "timeout");
      end
   end

   initial begin : stimulus
      rst_n     = 1'b0;
      bus.rw    = 1'b1;
      bus.write = 16'hFFFF;

      // Reset held across two edges with a pending write.
      step(1'b1, 16'hFFFF, 16'h0000, 1'b0, "reset_edge0");
      step(1'b1, 16'hFFFF, 16'h0000, 1'b0, "reset_edge1");
      rst_n = 1'b1;

      step(1'b1, 16'h3524, 16'h3524, 1'b1, "write_3524");
      step(1'b0, 16'h5E81, 16'h3524, 1'b0, "hold0");
      step(1'b0, 16'h5E81, 16'h3524, 1'b0, "hold1");

      step(1'b1, 16'hD609, 16'hD609, 1'b1, "alt_w_D609");
      step(1'b0, 16'h5663, 16'hD609, 1'b0, "alt_r_5663");
      step(1'b1, 16'h7B0D, 16'h7B0D, 1'b1, "alt_w_7B0D");

      step(1'b1, 16'h7B0D, 16'h7B0D, 1'b0, "same_7B0D");
      step(1'b1, 16'h0000, 16'h0000, 1'b1, "write_zero");
      step(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, "write_ffff");
      step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, "same_ffff");
      step(1'b1, 16'h1234, 16'h1234, 1'b1, "b2b_1234");
      step(1'b1, 16'h4321, 16'h4321, 1'b1, "b2b_4321");
      step(1'b0, 16'hAAAA, 16'h4321, 1'b0, "upd_clears");

      // Mid-cycle async reset with a write pending (q=4321, updated=0).
      bus.rw    = 1'b1;
      bus.write = 16'hABCD;
      #1;
`ifdef REGISTER_RW_BYPASS_EN
      probe(16'hABCD, 1'b0, "bypass_pre_edge");
`else
      probe(16'h4321, 1'b0, "no_bypass_pre_edge");
`endif
      #1;
      rst_n = 1'b0;
      #1;
      probe(16'h0000, 1'b0, "async_reset_now");
      @(posedge clk);
      expect_val(16'h0000, 1'b0, "reset_no_capture");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, 16'h5555, 16'h0000, 1'b0, "post_reset_hold");
      step(1'b1, 16'hBEEF, 16'hBEEF, 1'b1, "write_beef");

      // Async reset while updated is high must clear it at once.
      bus.rw = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      probe(16'h0000, 1'b0, "async_clr_updated");
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 16'h0000, 16'h0000, 1'b0, "same_as_reset_val");

      @(negedge clk);
      #1;
      n_compared++;
      if (exp_q.size() != 0) begin
         n_failed++;
         $display("FAIL queue_drain: %0d pending, required 0", exp_q.size());
      end

      stim_done = 1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
